// File: rtl/adder_rr_sched.sv
// Round-robin front end that time-shares one fixed-latency pipelined adder between NUM_REQ
// requesters, tagging each issue so the sum is returned to the requester that sent it.
module adder_rr_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_IN  = 8,
  parameter int unsigned BITS    = 8,
  parameter int unsigned LATENCY = 3,
  localparam int unsigned IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*NUM_IN*BITS-1:0]  req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            add_valid,
  output logic [NUM_IN*BITS-1:0]          add_data,
  input  logic [BITS-1:0]                 add_o,
  input  logic                            add_valid_out,
  output logic                            rsp_valid,
  output logic [IDW-1:0]                  rsp_id,
  output logic [BITS-1:0]                 rsp_data,
  output logic                            busy,
  output logic                            err_orphan
);

  localparam int unsigned DEPTH = LATENCY + 1;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic [IDW-1:0]         ptr_q;
  logic [IDW-1:0]         ptr_next;
  logic [IDW-1:0]         grant_id;
  logic [IDW-1:0]         idx_t;
  int unsigned            idx;
  logic                   grant_found;
  logic                   can_issue;
  logic                   push;
  logic                   pop;
  logic                   orphan;
  logic [NUM_IN*BITS-1:0] sel_data;

  logic [IDW-1:0]         tag_mem [DEPTH];
  logic [PW-1:0]          wr_q;
  logic [PW-1:0]          rd_q;
  logic [CW-1:0]          cnt_q;

  // A pop in the same cycle does not free a slot for a grant; keeps ready off the result path.
  assign can_issue = en & ~rst & (cnt_q < CW'(DEPTH));

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    idx_t       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_t = idx[IDW-1:0];
      if (!grant_found && req_valid[idx_t]) begin
        grant_found = 1'b1;
        grant_id    = idx_t;
      end
    end
  end

  always_comb begin
    push      = can_issue & grant_found;
    req_ready = '0;
    if (push) req_ready[grant_id] = 1'b1;
  end

  assign pop      = add_valid_out & (cnt_q != '0);
  assign orphan   = add_valid_out & (cnt_q == '0);
  assign busy     = (cnt_q != '0);
  assign sel_data = req_data[32'(grant_id)*NUM_IN*BITS +: NUM_IN*BITS];
  assign ptr_next = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      add_valid  <= 1'b0;
      add_data   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      err_orphan <= 1'b0;
      ptr_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      add_valid <= push;
      rsp_valid <= pop;
      if (push) begin
        add_data <= sel_data;
        ptr_q    <= ptr_next;
        wr_q     <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (pop) begin
        rsp_id   <= tag_mem[rd_q];
        rsp_data <= add_o;
        rd_q     <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      end
      if (orphan) err_orphan <= 1'b1;
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_q] <= grant_id;
  end

endmodule
